znc_flag_unit: RTL and testbench
================================

ZNC_FLAG_UNIT -- requirements
Module: znc_flag_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width of operands and result (minimum 2).
REQ-002 SHALL have parameter DEPTH, default 4, number of entries in the flag save stack (minimum 1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port op_a  input  WIDTH  first ALU operand.
REQ-006 SHALL have port op_b  input  WIDTH  second ALU operand.
REQ-007 SHALL have port result  input  WIDTH  ALU result for op_a/op_b.
REQ-008 SHALL have port sub  input  1  0 = result is op_a+op_b, 1 = result is op_a-op_b.
REQ-009 SHALL have port upd  input  1  load newly computed flags this cycle.
REQ-010 SHALL have port push  input  1  save current flags onto stack.
REQ-011 SHALL have port pop  input  1  restore flags from top of stack.
REQ-012 SHALL have port clr_err  input  1  clear sticky error.
REQ-013 SHALL have port flags  output  4  registered {Z,N,C,V}, bit 3 = Z.
REQ-014 SHALL have port stk_full  output  1  stack holds DEPTH entries.
REQ-015 SHALL have port stk_empty  output  1  stack holds 0 entries.
REQ-016 SHALL have port err  output  1  sticky stack misuse flag.

Function
REQ-017 SHALL compute, from MSBs a=op_a[WIDTH-1], b=op_b[WIDTH-1], r=result[WIDTH-1], combinational next flags: Z = (result == 0); N = r.
REQ-018 SHALL, sub=0, set C = (a&b) | (a&~r) | (b&~r) (unsigned carry-out) and V = (a==b) & (r!=a).
REQ-019 SHALL, sub=1, set C = (~a&b) | (~a&r) | (b&r) (borrow, 1 when op_a < op_b unsigned) and V = (a!=b) & (r!=a).
REQ-020 SHALL load next flags into flags on the clock edge where upd=1 and pop=0; flags visible one cycle after upd (latency 1); flags hold otherwise.
REQ-021 SHALL, on push=1, pop=0, not full: write pre-edge flags to stack at depth pointer, increment pointer; a simultaneous upd still loads new flags (stack gets old value).
REQ-022 SHALL, on pop=1, push=0, not empty: load flags from top entry, decrement pointer; a simultaneous upd is ignored (pop wins).
REQ-023 SHALL treat push=1 with stack full as a no-op on stack, set err; flags still follow upd.
REQ-024 SHALL treat pop=1 with stack empty as a no-op on flags and stack, set err; simultaneous upd then takes effect.
REQ-025 SHALL treat push=1 and pop=1 in the same cycle as illegal: stack and pointer unchanged, set err; upd takes effect.
REQ-026 SHALL drive stk_full = (count == DEPTH), stk_empty = (count == 0), both registered-state derived, no combinational path from inputs.
REQ-027 SHALL hold err at 1 until clr_err or rst; an error event in the same cycle as clr_err leaves err = 1.
REQ-028 SHALL use pointer width ceil(log2(DEPTH+1)); count never wraps past 0 or DEPTH.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set flags = 4'b0000, count = 0, stk_empty = 1, stk_full = 0, err = 0, regardless of all other inputs, including mid push/pop sequences.
REQ-030 SHALL not require stack contents to be cleared by reset; popped data is only defined after a push.

Verification
REQ-031 Add, WIDTH=16: op_a=16'hFFFF, op_b=16'h0001, result=16'h0000, sub=0, upd=1 -> next cycle flags = 4'b1010 (Z=1,N=0,C=1,V=0).
REQ-032 Add overflow: op_a=16'h7FFF, op_b=16'h0001, result=16'h8000, sub=0, upd=1 -> flags = 4'b0101 (N=1,V=1).
REQ-033 Sub borrow: op_a=16'h0001, op_b=16'h0002, result=16'hFFFF, sub=1, upd=1 -> flags = 4'b0110 (N=1,C=1).
REQ-034 DEPTH=4: five pushes from reset -> stk_full=1 after fourth, err=1 after fifth; four pops restore flags in reverse push order, stk_empty=1; extra pop leaves flags unchanged.
REQ-035 push+upd same cycle with flags=4'b1000, new=4'b0101 -> flags=4'b0101; later pop -> flags=4'b1000; pop+upd same cycle -> popped value wins.
REQ-036 rst asserted after two pushes with err=1 -> next cycle flags=0, stk_empty=1, err=0; push+pop same cycle -> err=1, count unchanged.

Source files
------------

// File: rtl/znc_flag_unit.sv
// Condition-flag unit: derives {Z,N,C,V} from an add/subtract result,
// holds them in a register and saves/restores them through a small stack.
// Misuse of the stack raises a sticky error that only clr_err or rst clears.
module znc_flag_unit #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] result,
   input  logic             sub,
   input  logic             upd,
   input  logic             push,
   input  logic             pop,
   input  logic             clr_err,
   output logic [3:0]       flags,
   output logic             stk_full,
   output logic             stk_empty,
   output logic             err
);

   // Count must represent 0..DEPTH inclusive; the address only needs 0..DEPTH-1.
   localparam int PW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [3:0]    flags_q, flags_d;
   logic [PW-1:0] count_q, count_d;
   logic          err_q, err_d;
   logic [3:0]    stack_q [2**AW];

   logic          a, b, r;
   logic [3:0]    new_flags;
   logic [PW-1:0] count_m1;
   logic [AW-1:0] wr_idx, rd_idx;
   logic          is_full, is_empty;
   logic          do_push, do_pop, err_event;

   assign a = op_a[WIDTH-1];
   assign b = op_b[WIDTH-1];
   assign r = result[WIDTH-1];

   assign is_full   = (count_q == PW'(DEPTH));
   assign is_empty  = (count_q == '0);
   assign count_m1  = count_q - PW'(1);
   assign wr_idx    = count_q[AW-1:0];
   assign rd_idx    = count_m1[AW-1:0];

   // Only a lone push/pop that the stack can honour touches it; everything
   // else that asks for the stack is misuse.
   assign do_push   = push & ~pop & ~is_full;
   assign do_pop    = pop & ~push & ~is_empty;
   assign err_event = (push & pop) | (push & ~pop & is_full) | (pop & ~push & is_empty);

   // Candidate flags from operand/result sign bits; C is carry for add, borrow for sub.
   always_comb begin
      // NOTE: every variable gets a value before any branch so no latch is inferred.
      new_flags    = '0;
      new_flags[3] = (result == '0);
      new_flags[2] = r;
      if (sub) begin
         new_flags[1] = (~a & b) | (~a & r) | (b & r);
         new_flags[0] = (a != b) & (r != a);
      end else begin
         new_flags[1] = (a & b) | (a & ~r) | (b & ~r);
         new_flags[0] = (a == b) & (r != a);
      end
   end

   // Next-state selection: a legal pop overrides upd; otherwise upd loads.
   always_comb begin
      flags_d = flags_q;
      count_d = count_q;
      err_d   = err_q;
      if (do_pop) begin
         flags_d = stack_q[rd_idx];
         count_d = count_m1;
      end else if (upd) begin
         flags_d = new_flags;
      end
      if (do_push) begin
         count_d = count_q + PW'(1);
      end
      // An error in the same cycle as clr_err wins so no event is lost.
      if (err_event) begin
         err_d = 1'b1;
      end else if (clr_err) begin
         err_d = 1'b0;
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (rst) begin
         flags_q <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         flags_q <= flags_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Stack storage; a push saves the flags as they were before this edge.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; entries are only read after being pushed.
      if (!rst && do_push) begin
         stack_q[wr_idx] <= flags_q;
      end
   end

   assign flags     = flags_q;
   assign stk_full  = is_full;
   assign stk_empty = is_empty;
   assign err       = err_q;

endmodule

// File: tb/tb_znc_flag_unit.sv
// Self-checking bench for znc_flag_unit: directed scenarios followed by
// random traffic, all checked against an arithmetic/queue reference model.
module tb_znc_flag_unit;

   localparam int W = 16;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst, sub, upd, push, pop, clr_err;
   logic [W-1:0] op_a, op_b, result;
   logic [3:0]   flags;
   logic         stk_full, stk_empty, err;

   // Reference state
   logic [3:0]   m_flags;
   logic         m_err;
   logic [3:0]   m_stk [$];

   int checks   = 0;
   int failures = 0;

   znc_flag_unit #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b), .result(result),
      .sub(sub), .upd(upd), .push(push), .pop(pop), .clr_err(clr_err),
      .flags(flags), .stk_full(stk_full), .stk_empty(stk_empty), .err(err)
   );

   always #5 clk = ~clk;

   // Flags from true integer arithmetic rather than sign-bit equations.
   function automatic logic [3:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
      int ux, uy, sx, sy, full_u, full_s;
      logic [W-1:0] res;
      logic z, n, c, v;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      full_u = s ? (ux - uy) : (ux + uy);
      full_s = s ? (sx - sy) : (sx + sy);
      res = full_u[W-1:0];
      z = (res == '0);
      n = res[W-1];
      c = s ? (ux < uy) : (full_u >= (1 << W));
      v = (full_s > ((1 << (W-1)) - 1)) || (full_s < -(1 << (W-1)));
      return {z, n, c, v};
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the model, then compare all outputs.
   task automatic step(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s, input logic u, input logic pu, input logic po,
                       input logic clr, input logic r);
      logic [3:0] old;
      logic full, empty, ev;
      op_a = x; op_b = y; sub = s; upd = u; push = pu; pop = po;
      clr_err = clr; rst = r;
      result = s ? (x - y) : (x + y);
      @(posedge clk);
      if (r) begin
         m_flags = 4'b0000;
         m_err   = 1'b0;
         m_stk.delete();
      end else begin
         old   = m_flags;
         full  = (m_stk.size() == D);
         empty = (m_stk.size() == 0);
         ev    = (pu && po) || (pu && !po && full) || (po && !pu && empty);
         if (po && !pu && !empty) m_flags = m_stk.pop_back();
         else if (u)              m_flags = ref_flags(x, y, s);
         if (pu && !po && !full)  m_stk.push_back(old);
         if (ev)                  m_err = 1'b1;
         else if (clr)            m_err = 1'b0;
      end
      #1;
      check({tag, ".flags"}, flags, m_flags);
      check({tag, ".full"},  {3'b0, stk_full},  {3'b0, m_stk.size() == D});
      check({tag, ".empty"}, {3'b0, stk_empty}, {3'b0, m_stk.size() == 0});
      check({tag, ".err"},   {3'b0, err},       {3'b0, m_err});
   endtask

   initial begin
      m_flags = '0;
      m_err   = 1'b0;

      // Reset state
      step("reset", '0, '0, 0, 0, 0, 0, 0, 1);

      // Known flag vectors
      step("add_zero_carry", 16'hFFFF, 16'h0001, 0, 1, 0, 0, 0, 0);
      check("add_zero_carry.const", flags, 4'b1010);
      step("add_overflow", 16'h7FFF, 16'h0001, 0, 1, 0, 0, 0, 0);
      check("add_overflow.const", flags, 4'b0101);
      step("sub_borrow", 16'h0001, 16'h0002, 1, 1, 0, 0, 0, 0);
      check("sub_borrow.const", flags, 4'b0110);
      step("sub_overflow", 16'h8000, 16'h0001, 1, 1, 0, 0, 0, 0);
      check("sub_overflow.const", flags, 4'b0001);
      step("hold", 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
      check("hold.const", flags, 4'b0001);

      // Fill, overflow, drain and underflow the stack, each push saving distinct flags
      step("fill_rst", '0, '0, 0, 0, 0, 0, 0, 1);
      step("push1", 16'hFFFF, 16'h0001, 0, 1, 1, 0, 0, 0);
      step("push2", 16'h7FFF, 16'h0001, 0, 1, 1, 0, 0, 0);
      step("push3", 16'h0001, 16'h0002, 1, 1, 1, 0, 0, 0);
      step("push4", 16'h0003, 16'h0004, 0, 1, 1, 0, 0, 0);
      check("push4.full_const", {3'b0, stk_full}, 4'b0001);
      step("push5_over", 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 0);
      check("push5.err_const", {3'b0, err}, 4'b0001);
      for (int i = 0; i < 4; i++) step("pop", 16'h1234, 16'h0001, 0, 0, 0, 1, 0, 0);
      check("drain.empty_const", {3'b0, stk_empty}, 4'b0001);
      step("pop_under", 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0);
      step("clr_err", 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0);
      step("err_vs_clr", 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0);
      step("clr_err2", 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0);

      // push+upd, pop restores, pop+upd
      step("set_1000", 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 0);
      step("push_upd", 16'h7FFF, 16'h0001, 0, 1, 1, 0, 0, 0);
      check("push_upd.const", flags, 4'b0101);
      step("pop_back", 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0);
      check("pop_back.const", flags, 4'b1000);
      step("push_again", 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 0);
      step("pop_upd", 16'hFFFF, 16'h0001, 0, 1, 0, 1, 0, 0);
      check("pop_upd.const", flags, 4'b1000);
      step("pop_empty_upd", 16'h7FFF, 16'h0001, 0, 1, 0, 1, 0, 0);

      // Reset in the middle of stack use with err set
      step("mid_push1", 16'h0001, 16'h0001, 0, 1, 1, 0, 0, 0);
      step("mid_push2", 16'h0002, 16'h0001, 1, 1, 1, 0, 0, 0);
      step("push_pop", 16'h0005, 16'h0001, 0, 1, 1, 1, 0, 0);
      step("rst_mid", 16'hFFFF, 16'h0001, 0, 1, 1, 0, 0, 1);
      check("rst_mid.flags_const", flags, 4'b0000);
      step("push_pop_empty", '0, '0, 0, 0, 1, 1, 0, 0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [W-1:0] x, y;
         x = W'($urandom);
         y = W'($urandom_range(0, 3) == 0 ? 0 : $urandom);
         if ($urandom_range(0, 7) == 0) y = x;
         step("rand", x, y, 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 60) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
